// File: rtl/mpu_fetch.sv
// mpu_fetch: instruction fetch and 12-byte prefetch queue feeding the decoder.
// Reads 32-bit words from instruction memory (1-cycle latency) and presents a
// 48-bit little-endian window starting at byte pc. Consume advances the window
// by isize bytes. Jump redirects to any byte address.
//
// Ports:
//   sys_clk, sys_rst     clock, synchronous active-high reset
//   en                   fetch enable (gates new reads only)
//   mem_re, mem_adr      word read request and word address
//   mem_dat              read data, valid the cycle after mem_re
//   i, i_valid, pc       instruction window, 6-bytes-valid flag, byte PC
//   consume, isize       retire current instruction of isize (1..6) bytes
//   jump, jaddr          redirect to jaddr (wins over consume)
//   error                sticky illegal-consume flag
module mpu_fetch (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  output logic        mem_re,
  output logic [13:0] mem_adr,
  input  logic [31:0] mem_dat,
  output logic [47:0] i,
  output logic        i_valid,
  output logic [15:0] pc,
  input  logic        consume,
  input  logic [15:0] isize,
  input  logic        jump,
  input  logic [15:0] jaddr,
  output logic        error
);

  localparam int unsigned QBYTES    = 12;
  localparam int unsigned WIN_BYTES = 6;
  localparam int unsigned QW        = 8 * QBYTES;

  // Registered state
  logic [QW-1:0] q_r;
  logic [3:0]    cnt_r;
  logic [13:0]   fa_r;
  logic          pend_r;
  logic          squash_r;
  logic [1:0]    skip_r;

  // Next-state values
  logic [QW-1:0] q_n;
  logic [QW-1:0] q_s;
  logic [3:0]    cnt_n;
  logic [3:0]    cnt_a;
  logic [13:0]   fa_n;
  logic          squash_n;
  logic [1:0]    skip_n;
  logic [15:0]   pc_n;
  logic          err_n;

  logic          size_ok;
  logic          cons_ok;
  logic          cons_bad;
  logic          capture;
  logic          req;
  logic [2:0]    sh;
  logic [2:0]    nb;
  logic [4:0]    fill_lvl;
  logic [1:0]    idx;

  // Request/consume/capture qualification
  always_comb begin
    size_ok  = (isize != 16'd0) && (isize <= 16'd6);
    cons_ok  = consume & ~jump & i_valid & size_ok;
    cons_bad = consume & ~jump & ~cons_ok;
    // A word returning in a jump cycle, or marked stale, is dropped.
    capture  = pend_r & ~squash_r & ~jump;
    // Count the in-flight word so the queue can always absorb it.
    fill_lvl = {1'b0, cnt_r} + (pend_r ? 5'd4 : 5'd0);
    req      = ~sys_rst & en & ~jump & (fill_lvl <= 5'd8);
  end

  assign mem_re  = req;
  assign mem_adr = fa_r;
  assign i       = q_r[8*WIN_BYTES-1:0];

  // Queue shift on consume, then append accepted word bytes behind the survivors
  always_comb begin
    sh    = cons_ok ? isize[2:0] : 3'd0;
    cnt_a = cnt_r - {1'b0, sh};
    nb    = 3'd4 - {1'b0, skip_r};
    q_s   = q_r >> {sh, 3'b000};
    q_n   = q_s;
    idx   = 2'd0;
    if (capture) begin
      for (int b = 0; b < QBYTES; b++) begin
        if ((5'(b) >= {1'b0, cnt_a}) &&
            ((5'(b) - {1'b0, cnt_a}) < {2'b00, nb})) begin
          idx = 2'(5'(b) - {1'b0, cnt_a} + {3'b000, skip_r});
          q_n[8*b +: 8] = mem_dat[{idx, 3'b000} +: 8];
        end
      end
    end
  end

  // Pointer, count and flag updates; jump overrides consume and capture
  always_comb begin
    cnt_n    = cnt_a + (capture ? {1'b0, nb} : 4'd0);
    fa_n     = req ? fa_r + 14'd1 : fa_r;
    skip_n   = capture ? 2'd0 : skip_r;
    squash_n = 1'b0;
    pc_n     = pc + (cons_ok ? isize : 16'd0);
    err_n    = error | cons_bad;
    if (jump) begin
      cnt_n    = 4'd0;
      fa_n     = jaddr[15:2];
      skip_n   = jaddr[1:0];
      squash_n = pend_r;
      pc_n     = jaddr;
    end
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      q_r      <= '0;
      cnt_r    <= 4'd0;
      fa_r     <= 14'd0;
      pend_r   <= 1'b0;
      squash_r <= 1'b0;
      skip_r   <= 2'd0;
      pc       <= 16'd0;
      error    <= 1'b0;
      i_valid  <= 1'b0;
    end else begin
      q_r      <= q_n;
      cnt_r    <= cnt_n;
      fa_r     <= fa_n;
      pend_r   <= req;
      squash_r <= squash_n;
      skip_r   <= skip_n;
      pc       <= pc_n;
      error    <= err_n;
      i_valid  <= (cnt_n >= 4'd6);
    end
  end

endmodule

// File: tb/tb_mpu_fetch.sv
// Self-checking bench for mpu_fetch: directed scenarios plus a randomized run
// checked against an address-level reference (expected pc, fetch address,
// sticky error, window contents as a function of pc).
module tb_mpu_fetch;

  logic        sys_clk;
  logic        sys_rst;
  logic        en;
  logic        mem_re;
  logic [13:0] mem_adr;
  logic [31:0] mem_dat;
  logic [47:0] i;
  logic        i_valid;
  logic [15:0] pc;
  logic        consume;
  logic [15:0] isize;
  logic        jump;
  logic [15:0] jaddr;
  logic        error;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic        m_err;
  logic [13:0] m_fa;
  int          idle;

  mpu_fetch dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (en),
    .mem_re  (mem_re),
    .mem_adr (mem_adr),
    .mem_dat (mem_dat),
    .i       (i),
    .i_valid (i_valid),
    .pc      (pc),
    .consume (consume),
    .isize   (isize),
    .jump    (jump),
    .jaddr   (jaddr),
    .error   (error)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Each memory byte holds the low byte of its own address.
  function automatic logic [31:0] word_at(input logic [13:0] wa);
    logic [31:0] w;
    logic [15:0] a;
    for (int k = 0; k < 4; k++) begin
      a = {wa, 2'b00} + 16'(k);
      w[8*k +: 8] = a[7:0];
    end
    return w;
  endfunction

  function automatic logic [47:0] win(input logic [15:0] a);
    logic [47:0] w;
    logic [15:0] t;
    for (int k = 0; k < 6; k++) begin
      t = a + 16'(k);
      w[8*k +: 8] = t[7:0];
    end
    return w;
  endfunction

  always @(posedge sys_clk) mem_dat <= mem_re ? word_at(mem_adr) : $urandom;

  task automatic drive(input logic r, input logic e, input logic c,
                       input logic [15:0] s, input logic j, input logic [15:0] ja);
    sys_rst = r; en = e; consume = c; isize = s; jump = j; jaddr = ja;
    #1;
  endtask

  // Update the reference for the cycle just observed, then move to the next.
  task automatic advance();
    if (sys_rst) begin
      m_pc = 16'd0; m_err = 1'b0; m_fa = 14'd0; idle = 0;
    end else begin
      if (mem_re) m_fa = m_fa + 14'd1;
      if (jump) begin
        m_pc = jaddr; m_fa = jaddr[15:2]; idle = 0;
      end else if (consume) begin
        if (i_valid && isize >= 16'd1 && isize <= 16'd6) m_pc = m_pc + isize;
        else m_err = 1'b1;
        idle = 0;
      end else if (en) idle++;
      else idle = 0;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 0, 0, 0); advance();
    drive(1, 1, 0, 0, 0, 0); advance();
    drive(1, 1, 0, 0, 0, 0);
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem_re got %b want 0", mem_re); end
    advance();
    drive(0, 1, 0, 0, 0, 0);
    checks++; if (pc !== 16'd0 || i !== 48'd0 || i_valid !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL reset_state got pc=%h i=%h v=%b err=%b want 0", pc, i, i_valid, error); end
    checks++; if (mem_re !== 1'b1 || mem_adr !== 14'd0) begin
      errors++; $display("FAIL first_read got re=%b adr=%h want 1/0", mem_re, mem_adr); end
    advance();
    drive(0, 1, 0, 0, 0, 0); advance();
    // Reset while word 1 is in flight; it must not leak into the queue.
    drive(1, 1, 0, 0, 0, 0); advance();
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 0, 0, 0, 0);
      if (c < 3) begin
        checks++; if (mem_re !== 1'b1 || mem_adr !== 14'(c)) begin
          errors++; $display("FAIL startup_read c%0d got re=%b adr=%h want 1/%h", c, mem_re, mem_adr, c); end
      end else begin
        checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL startup_noread c3 got %b want 0", mem_re); end
      end
      checks++; if (i_valid !== (c == 3)) begin
        errors++; $display("FAIL startup_valid c%0d got %b want %b", c, i_valid, c == 3); end
      if (c == 0) begin
        checks++; if (i !== 48'd0) begin errors++; $display("FAIL post_reset_window got %h want 0", i); end
      end
      if (c == 3) begin
        checks++; if (i !== 48'h050403020100 || pc !== 16'd0) begin
          errors++; $display("FAIL startup_window got i=%h pc=%h want 050403020100/0000", i, pc); end
      end
      advance();
    end
  endtask

  task automatic test_stream();
    int sz[4] = '{5, 2, 4, 3};
    int n = 0;
    int g = 0;
    logic [15:0] exp_pc = 16'd0;
    while (n < 12 && g < 100) begin
      if (i_valid) drive(0, 1, 1, 16'(sz[n % 4]), 0, 0);
      else drive(0, 1, 0, 0, 0, 0);
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL stream_pc n%0d got %h want %h", n, pc, exp_pc); end
      if (i_valid) begin
        checks++; if (i !== win(exp_pc)) begin errors++; $display("FAIL stream_window got %h want %h", i, win(exp_pc)); end
      end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL stream_error got %b want 0", error); end
      if (consume) begin exp_pc = exp_pc + 16'(sz[n % 4]); n++; end
      advance();
      g++;
    end
    checks++; if (n != 12) begin errors++; $display("FAIL stream_timeout consumed %0d want 12", n); end
  endtask

  task automatic test_jump_inflight();
    int g = 0;
    logic seen = 1'b0;
    while (!seen && g < 20) begin
      if (i_valid) drive(0, 1, 1, 16'd6, 0, 0);
      else drive(0, 1, 0, 0, 0, 0);
      seen = mem_re;
      advance();
      g++;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL jump_setup_read got %b want 1", seen); end
    drive(0, 1, 0, 0, 1, 16'h0103);
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL jump_cycle_read got %b want 0", mem_re); end
    advance();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 0, 0, 0, 0);
      if (k == 1) begin
        checks++; if (mem_re !== 1'b1 || mem_adr !== 14'h0040) begin
          errors++; $display("FAIL jump_first_read got re=%b adr=%h want 1/0040", mem_re, mem_adr); end
      end
      checks++; if (i_valid !== (k == 5)) begin
        errors++; $display("FAIL jump_valid t+%0d got %b want %b", k, i_valid, k == 5); end
      if (k == 5) begin
        checks++; if (i !== 48'h080706050403 || pc !== 16'h0103) begin
          errors++; $display("FAIL jump_window got i=%h pc=%h want 080706050403/0103", i, pc); end
      end
      advance();
    end
  endtask

  task automatic test_jump_consume();
    drive(0, 1, 1, 16'd3, 1, 16'h2000);
    advance();
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 0, 0, 0, 0);
      checks++; if (pc !== 16'h2000) begin errors++; $display("FAIL jc_pc t+%0d got %h want 2000", k, pc); end
      if (k == 1) begin
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL jc_error got %b want 0", error); end
      end
      checks++; if (i_valid !== (k == 4)) begin
        errors++; $display("FAIL jc_valid t+%0d got %b want %b", k, i_valid, k == 4); end
      if (k == 4) begin
        checks++; if (i !== win(16'h2000)) begin errors++; $display("FAIL jc_window got %h want %h", i, win(16'h2000)); end
      end
      advance();
    end
  endtask

  task automatic test_illegal();
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 0, 0, 0, 0); advance();
      drive(0, 1, 0, 0, 1, 16'h0300); advance();
      if (c == 0) begin
        drive(0, 1, 1, 16'd2, 0, 0);
        checks++; if (i_valid !== 1'b0) begin errors++; $display("FAIL ill_setup_valid got %b want 0", i_valid); end
        advance();
      end else begin
        for (int g = 0; g < 10 && !i_valid; g++) begin drive(0, 1, 0, 0, 0, 0); advance(); end
        drive(0, 1, 1, (c == 1) ? 16'd0 : 16'd7, 0, 0);
        advance();
      end
      drive(0, 1, 0, 0, 0, 0);
      checks++; if (pc !== 16'h0300 || error !== 1'b1) begin
        errors++; $display("FAIL ill_case%0d got pc=%h err=%b want 0300/1", c, pc, error); end
      if (c > 0) begin
        checks++; if (i !== win(16'h0300)) begin errors++; $display("FAIL ill_window case%0d got %h want %h", c, i, win(16'h0300)); end
      end
      advance();
      for (int g = 0; g < 10 && !i_valid; g++) begin drive(0, 1, 0, 0, 0, 0); advance(); end
      drive(0, 1, 1, 16'd2, 0, 0); advance();
      drive(0, 1, 0, 0, 0, 0);
      checks++; if (pc !== 16'h0302 || error !== 1'b1) begin
        errors++; $display("FAIL ill_sticky case%0d got pc=%h err=%b want 0302/1", c, pc, error); end
      advance();
    end
    drive(1, 1, 0, 0, 0, 0); advance();
    drive(0, 1, 0, 0, 0, 0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL ill_reset_clear got %b want 0", error); end
    advance();
  endtask

  task automatic test_wrap();
    drive(1, 1, 0, 0, 0, 0); advance();
    drive(0, 1, 0, 0, 1, 16'hFFFE); advance();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) drive(0, 1, 1, 16'd4, 0, 0);
      else drive(0, 1, 0, 0, 0, 0);
      if (k == 1) begin
        checks++; if (mem_re !== 1'b1 || mem_adr !== 14'h3FFF) begin
          errors++; $display("FAIL wrap_read1 got re=%b adr=%h want 1/3fff", mem_re, mem_adr); end
      end
      if (k == 2) begin
        checks++; if (mem_re !== 1'b1 || mem_adr !== 14'h0000) begin
          errors++; $display("FAIL wrap_read2 got re=%b adr=%h want 1/0000", mem_re, mem_adr); end
      end
      if (k == 4) begin
        checks++; if (i_valid !== 1'b1 || i !== 48'h03020100FFFE) begin
          errors++; $display("FAIL wrap_window got v=%b i=%h want 1/03020100fffe", i_valid, i); end
      end
      advance();
    end
    drive(0, 1, 0, 0, 0, 0);
    checks++; if (pc !== 16'h0002 || i_valid !== 1'b1 || i !== win(16'h0002)) begin
      errors++; $display("FAIL wrap_consume got pc=%h v=%b i=%h want 0002/1/%h", pc, i_valid, i, win(16'h0002)); end
    advance();
  endtask

  task automatic test_random();
    logic r, e, c, j;
    logic [15:0] s, ja;
    for (int n = 0; n < 2000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 9) != 0);
      j  = ($urandom_range(0, 29) == 0);
      ja = 16'($urandom);
      c  = 1'b0;
      s  = 16'd0;
      if (i_valid && $urandom_range(0, 4) != 0) begin c = 1'b1; s = 16'($urandom_range(1, 6)); end
      if ($urandom_range(0, 99) == 0) begin c = 1'b1; s = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'd7; end
      drive(r, e, c, s, j, ja);
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc n%0d got %h want %h", n, pc, m_pc); end
      checks++; if (error !== m_err) begin errors++; $display("FAIL rnd_error n%0d got %b want %b", n, error, m_err); end
      if (r || j || !e) begin
        checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL rnd_blocked_read n%0d got %b want 0", n, mem_re); end
      end
      if (mem_re) begin
        checks++; if (mem_adr !== m_fa) begin errors++; $display("FAIL rnd_adr n%0d got %h want %h", n, mem_adr, m_fa); end
      end
      if (i_valid) begin
        checks++; if (i !== win(m_pc)) begin errors++; $display("FAIL rnd_window n%0d got %h want %h", n, i, win(m_pc)); end
      end
      if (idle >= 4) begin
        checks++; if (i_valid !== 1'b1) begin errors++; $display("FAIL rnd_starved n%0d got %b want 1", n, i_valid); end
      end
      advance();
    end
  endtask

  initial begin
    m_pc = 16'd0; m_err = 1'b0; m_fa = 14'd0; idle = 0;
    test_reset();
    test_stream();
    test_jump_inflight();
    test_jump_consume();
    test_illegal();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
